// File: rtl/bin_to_dec_scan.sv
// Binary-to-decimal 7-segment scan driver: sequential double-dabble conversion plus digit multiplexing.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most significant non-zero digit).
module bin_to_dec_scan #(
    parameter int unsigned BIN_W   = 8,
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update,
    input  logic [BIN_W-1:0]  bin_in,
    output logic [6:0]        dk,
    output logic [DIGITS-1:0] select,
    output logic              busy,
    output logic              overflow
);
    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CMP_W = ((BIN_W > BCD_W) ? BIN_W : BCD_W) + 1;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [CMP_W-1:0] pow10(input int unsigned n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int unsigned i = 0; i < n; i++) p = p * CMP_W'(10);
        return p;
    endfunction

    localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_iter;
    logic               r_ovf_next;
    logic [BCD_W-1:0]   r_disp;
    logic               r_overflow;
    logic               r_busy;
    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         r_dk;
    logic [DIGITS-1:0]  r_sel;

    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BCD_W+BIN_W-1:0] w_next;
    logic [3:0]             w_digit;
    logic                   w_blank;
    logic [6:0]             w_seg;
    logic [DIGITS-1:0]      w_onehot;
    logic                   w_tick;
    int unsigned            w_idx;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_next = {w_bcd_adj, r_shift} << 1;
    end

    always_comb begin
        w_idx    = 32'(r_idx);
        w_digit  = r_disp[4*w_idx +: 4];
        w_onehot = '0;
        w_onehot[r_idx] = 1'b1;
        w_blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Blank only if this digit and every higher digit are zero; units always shown.
        w_blank = (w_idx != 0);
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (j >= w_idx && r_disp[4*j +: 4] != 4'd0) w_blank = 1'b0;
        end
`endif
        if (r_overflow)   w_seg = 7'b0000001;
        else if (w_blank) w_seg = 7'b0000000;
        else              w_seg = seg7(w_digit);
    end

    assign w_tick = (r_div == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_ovf_next <= 1'b0;
            r_disp     <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (update) begin
                    r_shift    <= bin_in;
                    r_bcd      <= '0;
                    r_iter     <= CNT_W'(BIN_W);
                    r_ovf_next <= (CMP_W'(bin_in) >= LIMIT);
                    r_busy     <= 1'b1;
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd   <= w_next[BIN_W +: BCD_W];
                    r_shift <= w_next[BIN_W-1:0];
                    r_iter  <= r_iter - 1'b1;
                    if (r_iter == CNT_W'(1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_disp     <= r_bcd;
                    r_overflow <= r_ovf_next;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
            r_dk  <= '0;
            r_sel <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_sel <= w_onehot;
                r_dk  <= w_seg;
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign dk       = r_dk;
    assign select   = r_sel;
    assign busy     = r_busy;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_bin_to_dec_scan.sv
// Directed bench for bin_to_dec_scan: 3-digit and 2-digit instances, scan period DIV=4.
module tb_bin_to_dec_scan;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       upd3, upd2;
    logic [7:0] bin3, bin2;
    logic [6:0] dk3, dk2;
    logic [2:0] sel3;
    logic [1:0] sel2;
    logic       busy3, busy2, ovf3, ovf2;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    bin_to_dec_scan #(.BIN_W(8), .DIGITS(3), .CLK_HZ(400), .SCAN_HZ(100)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .update(upd3), .bin_in(bin3),
        .dk(dk3), .select(sel3), .busy(busy3), .overflow(ovf3));

    bin_to_dec_scan #(.BIN_W(8), .DIGITS(2), .CLK_HZ(400), .SCAN_HZ(100)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .update(upd2), .bin_in(bin2),
        .dk(dk2), .select(sel2), .busy(busy2), .overflow(ovf2));

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] bin;
        logic [3:0] d0, d1, d2;
        logic [2:0] blank;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] exp_seg(input logic [3:0] d, input logic blank);
        if (BLANK_ON && blank) return 7'b0000000;
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic convert3(input logic [7:0] v, input string nm);
        int hi = 0;
        bin3 = v; upd3 = 1'b1; cyc(1); upd3 = 1'b0;
        while (busy3 && hi < 40) begin hi++; cyc(1); end
        check({nm, "_busy_cycles"}, 32'(hi), 32'd9);
    endtask

    task automatic convert2(input logic [7:0] v, input string nm);
        int hi = 0;
        bin2 = v; upd2 = 1'b1; cyc(1); upd2 = 1'b0;
        while (busy2 && hi < 40) begin hi++; cyc(1); end
        check({nm, "_busy_cycles"}, 32'(hi), 32'd9);
    endtask

    // Wait for a fresh tick onto the wanted digit so the sampled dk reflects current display data.
    task automatic scan3(input logic [2:0] s, input logic [6:0] e, input string nm);
        int n = 0;
        while (sel3 == s && n < 100) begin cyc(1); n++; end
        while (sel3 != s && n < 100) begin cyc(1); n++; end
        check({nm, "_sel"}, 32'(sel3), 32'(s));
        check(nm, 32'(dk3), 32'(e));
    endtask

    task automatic scan2(input logic [1:0] s, input logic [6:0] e, input string nm);
        int n = 0;
        while (sel2 == s && n < 100) begin cyc(1); n++; end
        while (sel2 != s && n < 100) begin cyc(1); n++; end
        check({nm, "_sel"}, 32'(sel2), 32'(s));
        check(nm, 32'(dk2), 32'(e));
    endtask

    initial begin
        vecs[0] = '{bin: 8'd0,   d0: 4'd0, d1: 4'd0, d2: 4'd0, blank: 3'b110};
        vecs[1] = '{bin: 8'd7,   d0: 4'd7, d1: 4'd0, d2: 4'd0, blank: 3'b110};
        vecs[2] = '{bin: 8'd42,  d0: 4'd2, d1: 4'd4, d2: 4'd0, blank: 3'b100};
        vecs[3] = '{bin: 8'd100, d0: 4'd0, d1: 4'd0, d2: 4'd1, blank: 3'b000};
        vecs[4] = '{bin: 8'd9,   d0: 4'd9, d1: 4'd0, d2: 4'd0, blank: 3'b110};
        vecs[5] = '{bin: 8'd99,  d0: 4'd9, d1: 4'd9, d2: 4'd0, blank: 3'b100};
        vecs[6] = '{bin: 8'd128, d0: 4'd8, d1: 4'd2, d2: 4'd1, blank: 3'b000};
        vecs[7] = '{bin: 8'd255, d0: 4'd5, d1: 4'd5, d2: 4'd2, blank: 3'b000};

        rst_n = 1'b0; upd3 = 1'b0; upd2 = 1'b0; bin3 = '0; bin2 = '0;
        cyc(3);
        check("rst_dk", 32'(dk3), 32'd0);
        check("rst_sel", 32'(sel3), 32'd0);
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_ovf", 32'(ovf3), 32'd0);
        rst_n = 1'b1;
        cyc(2);
        check("pre_tick_sel", 32'(sel3), 32'd0);
        check("pre_tick_dk", 32'(dk3), 32'd0);
        scan3(3'b001, 7'b1111110, "first_tick_units");

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("v%0d", vecs[i].bin);
            convert3(vecs[i].bin, nm);
            check({nm, "_ovf"}, 32'(ovf3), 32'd0);
            scan3(3'b001, exp_seg(vecs[i].d0, vecs[i].blank[0]), {nm, "_units"});
            scan3(3'b010, exp_seg(vecs[i].d1, vecs[i].blank[1]), {nm, "_tens"});
            scan3(3'b100, exp_seg(vecs[i].d2, vecs[i].blank[2]), {nm, "_hund"});
        end

        // Second update two cycles into a conversion must be dropped.
        begin
            int n = 0;
            bin3 = 8'd42; upd3 = 1'b1; cyc(1); upd3 = 1'b0;
            cyc(1);
            bin3 = 8'd17; upd3 = 1'b1; cyc(1); upd3 = 1'b0;
            while (busy3 && n < 40) begin n++; cyc(1); end
            check("ignore_idle", 32'(busy3), 32'd0);
            scan3(3'b001, exp_seg(4'd2, 1'b0), "ignore_units");
            scan3(3'b010, exp_seg(4'd4, 1'b0), "ignore_tens");
            scan3(3'b100, exp_seg(4'd0, 1'b1), "ignore_hund");
        end

        // Update held high: one conversion every BIN_W+2 cycles.
        begin
            int n = 0;
            int per = 0;
            bin3 = 8'd3; upd3 = 1'b1;
            while (!busy3 && n < 20) begin cyc(1); n++; end
            while (busy3 && per < 40) begin cyc(1); per++; end
            while (!busy3 && per < 40) begin cyc(1); per++; end
            check("b2b_period", 32'(per), 32'd10);
            upd3 = 1'b0;
            n = 0;
            while (busy3 && n < 40) begin cyc(1); n++; end
            scan3(3'b001, exp_seg(4'd3, 1'b0), "b2b_units");
        end

        // Two-digit instance: overflow boundary.
        convert2(8'd100, "d2_100");
        check("d2_100_ovf", 32'(ovf2), 32'd1);
        scan2(2'b01, 7'b0000001, "d2_100_units");
        scan2(2'b10, 7'b0000001, "d2_100_tens");
        convert2(8'd99, "d2_99");
        check("d2_99_ovf", 32'(ovf2), 32'd0);
        scan2(2'b01, 7'b1111011, "d2_99_units");
        scan2(2'b10, 7'b1111011, "d2_99_tens");
        convert2(8'd255, "d2_255");
        check("d2_255_ovf", 32'(ovf2), 32'd1);
        scan2(2'b10, 7'b0000001, "d2_255_tens");

        // Reset in the middle of a conversion.
        bin3 = 8'd200; upd3 = 1'b1; cyc(1); upd3 = 1'b0;
        cyc(4);
        check("midrst_busy_before", 32'(busy3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_dk", 32'(dk3), 32'd0);
        check("midrst_sel", 32'(sel3), 32'd0);
        check("midrst_busy", 32'(busy3), 32'd0);
        check("midrst_ovf2", 32'(ovf2), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        convert3(8'd5, "after_rst");
        scan3(3'b001, exp_seg(4'd5, 1'b0), "after_rst_units");
        scan3(3'b010, exp_seg(4'd0, 1'b1), "after_rst_tens");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
